// File: rtl/mac_ctrl.sv
// mac_ctrl: sequencer for the 3x3 matrix MAC datapath.
// Fetches three A-row and three B-row words, presents them to the MAC wrapper,
// writes the three result words back and pulses done_o.
// Optional error abort is compiled in with `define MAC_CTRL_ERR_EN.
module mac_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  opcode_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] rd_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic [1:0]  mac_opcode_o,
    output logic [31:0] mac_data1_o,
    output logic [31:0] mac_data2_o,
    output logic [31:0] mac_data3_o,
    output logic [31:0] mac_data4_o,
    output logic [31:0] mac_data5_o,
    output logic [31:0] mac_data6_o,
`ifdef MAC_CTRL_ERR_EN
    output logic        err_o,
    input  logic        mem_err_i,
`endif
    input  logic [31:0] mac_res1_i,
    input  logic [31:0] mac_res2_i,
    input  logic [31:0] mac_res3_i
);

    localparam int unsigned DW     = 32;
    localparam int unsigned N_OPS  = 6;
    localparam int unsigned N_RES  = 3;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_WR_REQ  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [DW-1:0] rs1_q, rs1_d;
    logic [DW-1:0] rs2_q, rs2_d;
    logic [DW-1:0] rd_q, rd_d;
    logic [1:0]    opc_q, opc_d;
    logic [DW-1:0] op_q [N_OPS];
    logic [DW-1:0] op_d [N_OPS];
    logic [DW-1:0] res_q [N_RES];
    logic [DW-1:0] res_d [N_RES];

    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
`ifdef MAC_CTRL_ERR_EN
    logic          err_q, err_d;
    logic          abort;
`endif

    // Next-state logic plus registered outputs decoded from the next state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        opc_d   = opc_q;
        op_d    = op_q;
        res_d   = res_q;
        req_d   = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef MAC_CTRL_ERR_EN
        err_d   = 1'b0;
        abort   = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    rs1_d   = rs1_i & ~32'd3;
                    rs2_d   = rs2_i & ~32'd3;
                    rd_d    = rd_i & ~32'd3;
                    opc_d   = opcode_i;
                    idx_d   = 3'd0;
                    state_d = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (mem_gnt_i) begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (mem_rvalid_i) begin
`ifdef MAC_CTRL_ERR_EN
                    if (mem_err_i) begin
                        abort   = 1'b1;
                        state_d = S_DONE;
                    end else
`endif
                    begin
                        op_d[idx_q] = mem_rdata_i;
                        if (idx_q == 3'd5) begin
                            state_d = S_EXEC;
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            state_d = S_RD_REQ;
                        end
                    end
                end
            end
            S_EXEC: begin
                res_d[0] = mac_res1_i;
                res_d[1] = mac_res2_i;
                res_d[2] = mac_res3_i;
                idx_d    = 3'd0;
                state_d  = S_WR_REQ;
            end
            S_WR_REQ: begin
                if (mem_gnt_i) begin
`ifdef MAC_CTRL_ERR_EN
                    if (mem_err_i) begin
                        abort   = 1'b1;
                        state_d = S_DONE;
                    end else
`endif
                    if (idx_q == 3'd2) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so decode them from the state being entered
        case (state_d)
            S_RD_REQ: begin
                req_d = 1'b1;
                if (idx_d < 3'd3) begin
                    addr_d = rs1_d + {27'd0, idx_d, 2'b00};
                end else begin
                    addr_d = rs2_d + {27'd0, 3'(idx_d - 3'd3), 2'b00};
                end
            end
            S_WR_REQ: begin
                req_d   = 1'b1;
                we_d    = 1'b1;
                addr_d  = rd_d + {27'd0, idx_d, 2'b00};
                wdata_d = res_d[idx_d[1:0]];
            end
            default: begin
            end
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
`ifdef MAC_CTRL_ERR_EN
        err_d  = abort;
`endif
    end

    // State, operand/result and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            opc_q   <= '0;
            for (int i = 0; i < N_OPS; i++) begin
                op_q[i] <= '0;
            end
            for (int i = 0; i < N_RES; i++) begin
                res_q[i] <= '0;
            end
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MAC_CTRL_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            opc_q   <= opc_d;
            op_q    <= op_d;
            res_q   <= res_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MAC_CTRL_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign mem_req_o    = req_q;
    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mac_opcode_o = opc_q;
    assign mac_data1_o  = op_q[0];
    assign mac_data2_o  = op_q[1];
    assign mac_data3_o  = op_q[2];
    assign mac_data4_o  = op_q[3];
    assign mac_data5_o  = op_q[4];
    assign mac_data6_o  = op_q[5];
`ifdef MAC_CTRL_ERR_EN
    assign err_o        = err_q;
`endif

endmodule

// File: tb/tb_mac_ctrl.sv
// Scoreboard bench for mac_ctrl: stimulus pushes expected memory transactions
// and completion records; a negedge monitor models memory and checks them.
module tb_mac_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  opcode_i;
    logic [31:0] rs1_i, rs2_i, rd_i;
    logic        busy_o, done_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [1:0]  mac_opcode_o;
    logic [31:0] mac_data1_o, mac_data2_o, mac_data3_o;
    logic [31:0] mac_data4_o, mac_data5_o, mac_data6_o;
    logic [31:0] mac_res1_i, mac_res2_i, mac_res3_i;
`ifdef MAC_CTRL_ERR_EN
    logic        err_o;
    logic        mem_err_i;
    int          err_rd_idx = -1;
`endif

    mac_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .opcode_i(opcode_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
        .busy_o(busy_o), .done_o(done_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .mac_opcode_o(mac_opcode_o),
        .mac_data1_o(mac_data1_o), .mac_data2_o(mac_data2_o), .mac_data3_o(mac_data3_o),
        .mac_data4_o(mac_data4_o), .mac_data5_o(mac_data5_o), .mac_data6_o(mac_data6_o),
`ifdef MAC_CTRL_ERR_EN
        .err_o(err_o), .mem_err_i(mem_err_i),
`endif
        .mac_res1_i(mac_res1_i), .mac_res2_i(mac_res2_i), .mac_res3_i(mac_res3_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        int              cyc;
        logic [1:0]      opc;
        logic [5:0][31:0] d;
        logic            chk_d;
        logic            err;
    } done_t;

    txn_t  exp_q[$];
    done_t exp_done_q[$];

    int checks   = 0;
    int failures = 0;

    // Memory behaviour configured by stimulus, consumed by the monitor
    logic [31:0] rd_data [6];
    int          rd_stall [6];
    int          wr_stall [3];

    logic [31:0] macd [6];
    always_comb begin
        macd[0] = mac_data1_o;
        macd[1] = mac_data2_o;
        macd[2] = mac_data3_o;
        macd[3] = mac_data4_o;
        macd[4] = mac_data5_o;
        macd[5] = mac_data6_o;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h cycle=%0d", name, act, expv, cyc);
        end
    endtask

    // Monitor and memory model: grants, stability, transaction and completion checks
    int          rd_n = 0, wr_n = 0, wait_left = 0;
    logic        held = 1'b0;
    logic [31:0] held_addr = '0;
    int          gseq = 0, gidx = 0;
    logic [31:0] gdata = '0;

    always @(negedge clk_i) begin
        txn_t  e;
        done_t de;
        if (rst_i) begin
            mem_gnt_i = 1'b0;
            held      = 1'b0;
            chk("rst_req",   32'(mem_req_o),    32'h0);
            chk("rst_busy",  32'(busy_o),       32'h0);
            chk("rst_done",  32'(done_o),       32'h0);
            chk("rst_addr",  mem_addr_o,        32'h0);
            chk("rst_wdata", mem_wdata_o,       32'h0);
            chk("rst_data1", mac_data1_o,       32'h0);
            chk("rst_opc",   32'(mac_opcode_o), 32'h0);
        end else begin
            if (start_i && !busy_o && !done_o) begin
                rd_n = 0;
                wr_n = 0;
            end
            if (done_o) begin
                if (exp_done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected cycle=%0d", cyc);
                end else begin
                    de = exp_done_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(de.cyc));
                    chk("opcode", 32'(mac_opcode_o), 32'(de.opc));
                    chk("pending_txns", 32'(exp_q.size()), 32'h0);
                    if (de.chk_d) begin
                        for (int i = 0; i < 6; i++) chk($sformatf("mac_data%0d", i + 1), macd[i], de.d[i]);
                    end
`ifdef MAC_CTRL_ERR_EN
                    chk("err_at_done", 32'(err_o), 32'(de.err));
`endif
                end
            end else begin
`ifdef MAC_CTRL_ERR_EN
                if (err_o) chk("err_no_done", 32'(err_o), 32'h0);
`endif
            end
            if (exp_done_q.size() != 0 && cyc > exp_done_q[0].cyc) begin
                checks++;
                failures++;
                $display("FAIL done_missing expected_cycle=%0d now=%0d", exp_done_q[0].cyc, cyc);
                void'(exp_done_q.pop_front());
            end
            if (mem_req_o) begin
                if (held) chk("held_addr", mem_addr_o, held_addr);
                else wait_left = mem_we_o ? ((wr_n < 3) ? wr_stall[wr_n] : 0)
                                          : ((rd_n < 6) ? rd_stall[rd_n] : 0);
                if (wait_left > 0) begin
                    wait_left--;
                    mem_gnt_i = 1'b0;
                    held      = 1'b1;
                    held_addr = mem_addr_o;
                end else begin
                    mem_gnt_i = 1'b1;
                    held      = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL req_unexpected we=%0d addr=0x%08h cycle=%0d", mem_we_o, mem_addr_o, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("txn_we", 32'(mem_we_o), 32'(e.we));
                        chk("txn_addr", mem_addr_o, e.addr);
                        if (e.we) chk("txn_wdata", mem_wdata_o, e.wdata);
                    end
                    if (!mem_we_o) begin
                        gdata = (rd_n < 6) ? rd_data[rd_n] : 32'h0;
                        gidx  = rd_n;
                        gseq++;
                        rd_n++;
                    end else begin
                        wr_n++;
                    end
                end
            end else begin
                mem_gnt_i = 1'b0;
                if (held) chk("req_dropped", 32'(mem_req_o), 32'h1);
                held = 1'b0;
            end
        end
    end

    // Read data returns in the cycle after the grant
    int seen = 0;
    always @(posedge clk_i) begin
        #1;
        if (gseq != seen && !rst_i) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = gdata;
`ifdef MAC_CTRL_ERR_EN
            mem_err_i    = (gidx == err_rd_idx);
`endif
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'h0;
`ifdef MAC_CTRL_ERR_EN
            mem_err_i    = 1'b0;
`endif
        end
        seen = gseq;
    end

    task automatic next_cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Push expected traffic for one instruction; lat=0 means no completion expected
    task automatic push_run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                            input logic [1:0] opc, input int n_rd, input int n_wr,
                            input int lat, input logic chk_d, input logic err);
        txn_t  t;
        done_t d;
        logic [31:0] res [3];
        res[0] = mac_res1_i;
        res[1] = mac_res2_i;
        res[2] = mac_res3_i;
        for (int i = 0; i < n_rd; i++) begin
            t.we    = 1'b0;
            t.addr  = (i < 3) ? ((a & ~32'd3) + 32'(4 * i)) : ((b & ~32'd3) + 32'(4 * (i - 3)));
            t.wdata = 32'h0;
            exp_q.push_back(t);
        end
        for (int i = 0; i < n_wr; i++) begin
            t.we    = 1'b1;
            t.addr  = (r & ~32'd3) + 32'(4 * i);
            t.wdata = res[i];
            exp_q.push_back(t);
        end
        if (lat > 0) begin
            d.cyc   = cyc + lat;
            d.opc   = opc;
            for (int i = 0; i < 6; i++) d.d[i] = rd_data[i];
            d.chk_d = chk_d;
            d.err   = err;
            exp_done_q.push_back(d);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                            input logic [1:0] opc);
        start_i  = 1'b1;
        rs1_i    = a;
        rs2_i    = b;
        rd_i     = r;
        opcode_i = opc;
        next_cyc(1);
        start_i  = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (exp_done_q.size() != 0 && k < 300) begin
            @(posedge clk_i);
            k++;
        end
        #1;
        if (exp_done_q.size() != 0) begin
            $display("FAIL wait_done timeout cycle=%0d", cyc);
            $fatal(1, "bench stalled");
        end
    endtask

    task automatic set_rd_data(input logic [31:0] base);
        for (int i = 0; i < 6; i++) rd_data[i] = base + 32'(i) * 32'h11;
    endtask

    initial begin
        int n;
        rst_i = 1'b1; start_i = 1'b0; opcode_i = 2'd0;
        rs1_i = '0; rs2_i = '0; rd_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        mac_res1_i = 32'hA1; mac_res2_i = 32'hA2; mac_res3_i = 32'hA3;
`ifdef MAC_CTRL_ERR_EN
        mem_err_i = 1'b0;
`endif
        for (int i = 0; i < 6; i++) rd_stall[i] = 0;
        for (int i = 0; i < 3; i++) wr_stall[i] = 0;
        set_rd_data(32'h11);
        next_cyc(3);
        rst_i = 1'b0;
        next_cyc(2);

        // Basic run: reads 0x100.., 0x200.., writes 0x300..
        push_run(32'h100, 32'h200, 32'h300, 2'd1, 6, 3, 17, 1'b1, 1'b0);
        start_op(32'h100, 32'h200, 32'h300, 2'd1);
        wait_done();

        // Backpressure: 3 cycles on 2nd read, 2 on 3rd write
        rd_stall[1] = 3; wr_stall[2] = 2;
        set_rd_data(32'h1000);
        mac_res1_i = 32'hB1; mac_res2_i = 32'hB2; mac_res3_i = 32'hB3;
        push_run(32'h400, 32'h500, 32'h600, 2'd2, 6, 3, 22, 1'b1, 1'b0);
        start_op(32'h400, 32'h500, 32'h600, 2'd2);
        wait_done();
        rd_stall[1] = 0; wr_stall[2] = 0;

        // Start pulsed mid-run with other operands is ignored
        set_rd_data(32'h2000);
        mac_res1_i = 32'hC1; mac_res2_i = 32'hC2; mac_res3_i = 32'hC3;
        n = cyc;
        push_run(32'h700, 32'h800, 32'h900, 2'd3, 6, 3, 17, 1'b1, 1'b0);
        start_op(32'h700, 32'h800, 32'h900, 2'd3);
        next_cyc(n + 5 - cyc);
        start_op(32'hDEAD0000, 32'hBEEF0000, 32'hCAFE0000, 2'd0);
        wait_done();

        // Alignment and address wrap
        set_rd_data(32'h3000);
        mac_res1_i = 32'hD1; mac_res2_i = 32'hD2; mac_res3_i = 32'hD3;
        push_run(32'h103, 32'h201, 32'hFFFFFFFA, 2'd0, 6, 3, 17, 1'b1, 1'b0);
        start_op(32'h103, 32'h201, 32'hFFFFFFFA, 2'd0);
        wait_done();

        // Reset during the 2nd write: only six reads and the first write occur
        set_rd_data(32'h4000);
        n = cyc;
        push_run(32'hA00, 32'hB00, 32'hC00, 2'd1, 6, 1, 0, 1'b0, 1'b0);
        start_op(32'hA00, 32'hB00, 32'hC00, 2'd1);
        next_cyc(n + 15 - cyc);
        rst_i = 1'b1;
        next_cyc(2);
        rst_i = 1'b0;
        next_cyc(6);

        // Fresh start after reset
        set_rd_data(32'h5000);
        mac_res1_i = 32'hE1; mac_res2_i = 32'hE2; mac_res3_i = 32'hE3;
        push_run(32'h100, 32'h200, 32'h300, 2'd2, 6, 3, 17, 1'b1, 1'b0);
        start_op(32'h100, 32'h200, 32'h300, 2'd2);
        wait_done();

`ifdef MAC_CTRL_ERR_EN
        // Error on the 4th read response aborts to DONE with err_o
        set_rd_data(32'h6000);
        err_rd_idx = 3;
        push_run(32'h100, 32'h200, 32'h300, 2'd3, 4, 0, 9, 1'b0, 1'b1);
        start_op(32'h100, 32'h200, 32'h300, 2'd3);
        wait_done();
        err_rd_idx = -1;
        next_cyc(4);
`endif

        next_cyc(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_ctrl.md
# mac_ctrl

Sequencer for the 3x3 matrix MAC datapath. It accepts one MAC instruction from the pipeline and reads the three matrix-A row words and the three matrix-B row words from data memory, one at a time. It then presents all six words with the opcode to the MAC wrapper, captures the three result words, writes them back to memory and signals completion. It sits between the execute stage (which it stalls via `busy_o`) and the data-memory port.

## Interface
Parameters: none.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset. One clock; reset is asynchronous and active-high.
- `start_i`  in  1  instruction valid; sampled only in IDLE.
- `opcode_i`  in  2  MAC opcode; captured at accept.
- `rs1_i`  in  32  matrix-A base address.
- `rs2_i`  in  32  matrix-B base address.
- `rd_i`  in  32  result base address.
- `busy_o`  out  1  pipeline stall request.
- `done_o`  out  1  one-cycle completion pulse.
- `mem_req_o`  out  1  memory request.
- `mem_we_o`  out  1  1 = write, 0 = read.
- `mem_addr_o`  out  32  word address; bits [1:0] always 0.
- `mem_wdata_o`  out  32  write data.
- `mem_gnt_i`  in  1  request accepted this cycle.
- `mem_rvalid_i`  in  1  read data valid.
- `mem_rdata_i`  in  32  read data.
- `mac_opcode_o`  out  2  to wrapper `opcode_i`.
- `mac_data1_o`..`mac_data6_o`  out  32 each  to wrapper `mem_data1_i`..`mem_data6_i`.
- `mac_res1_i`..`mac_res3_i`  in  32 each  from wrapper `mem_data1_o`..`mem_data3_o`.
- `err_o`  out  1  present only with `MAC_CTRL_ERR_EN`.
- `mem_err_i`  in  1  present only with `MAC_CTRL_ERR_EN`.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, EXEC, WR_REQ, DONE. A 3-bit index `idx` selects the current word.
- IDLE:
  - If `start_i` = 1, capture `rs1_i`, `rs2_i`, `rd_i` (bits [1:0] cleared) and `opcode_i`.
  - Set `idx` = 0 and go to RD_REQ.
- RD_REQ:
  - `mem_req_o` = 1, `mem_we_o` = 0.
  - Address for `idx` 0..2 is rs1 + 4·idx; for `idx` 3..5 it is rs2 + 4·(idx−3). Addition is mod 2^32.
  - Hold the request until `mem_gnt_i`, then go to RD_WAIT.
- RD_WAIT:
  - `mem_req_o` = 0. Wait for `mem_rvalid_i`, then store `mem_rdata_i` into operand register `idx`.
  - If `idx` = 5, go to EXEC; otherwise increment `idx` and go to RD_REQ.
  - At most one read is outstanding. An `mem_rvalid_i` outside RD_WAIT is ignored.
- EXEC: one cycle. Latch `mac_res1_i`..`mac_res3_i` into result registers, set `idx` = 0 and go to WR_REQ.
- WR_REQ:
  - `mem_req_o` = 1, `mem_we_o` = 1, address rd + 4·idx, `mem_wdata_o` = result[idx].
  - On `mem_gnt_i`: if `idx` = 2, go to DONE; otherwise increment `idx` and stay in WR_REQ.
- DONE: `done_o` = 1 for one cycle, then go to IDLE unconditionally.
- `busy_o` = 1 in every state except IDLE and DONE. `start_i` outside IDLE is ignored, with no queueing.
- `mac_data1_o`..`mac_data6_o` drive operand registers 0..5 continuously. `mac_opcode_o` drives the captured opcode.
- Address, write-data and write-enable outputs are don't-care while `mem_req_o` = 0 and are driven as 0.
- Reset values: all outputs 0, operand/result/address registers 0, state IDLE.
- Reset asserted mid-operation aborts immediately. No partial write completes after reset, and `done_o` is not pulsed.

## Timing
With `mem_gnt_i` tied to 1 and `mem_rvalid_i` arriving one cycle after grant, `start_i` accepted at cycle N gives:
- Reads: `mem_req_o` is high at N+1, N+3, …, N+11. The read data returns at N+2, N+4, …, N+12.
- EXEC at N+13. The wrapper is combinational, so its results are valid in that cycle.
- Writes at N+14, N+15, N+16.
- `done_o` at N+17. `busy_o` is high N+1..N+16. Earliest next accept is N+18.

Each cycle of withheld `mem_gnt_i`, or of delay in `mem_rvalid_i`, adds exactly one cycle.

## Configuration
`MAC_CTRL_ERR_EN`:
- Defined:
  - Adds `mem_err_i` and `err_o`.
  - `mem_err_i` = 1 together with `mem_rvalid_i` in RD_WAIT, or with `mem_gnt_i` in WR_REQ, aborts the sequence and goes to DONE. No further requests are issued.
  - In that DONE cycle, `done_o` = 1 and `err_o` = 1.
  - `err_o` is otherwise 0.
- Undefined: the ports are absent and error signalling does not exist.

## Test plan
- **Basic run.** rs1=0x100, rs2=0x200, rd=0x300, `mem_gnt_i`=1, memory returns 0x11..0x66, wrapper stub returns 0xA1/0xA2/0xA3.
  - Reads hit 0x100, 0x104, 0x108, 0x200, 0x204, 0x208.
  - `mac_data1..6_o` = 0x11..0x66.
  - Writes are 0x300←0xA1, 0x304←0xA2, 0x308←0xA3.
  - `done_o` at N+17.
- **Backpressure.** `mem_gnt_i` withheld 3 cycles on the 2nd read and 2 cycles on the 3rd write → address and `mem_req_o` are held stable, and `done_o` moves to N+22.
- **Ignored start.** `start_i` pulsed at N+5 with different operands → ignored; the original sequence completes unchanged.
- **Alignment and wrap.** rd=0xFFFFFFFA, rs1=0x103 → writes to 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; reads from 0x100.
- **Reset mid-operation.** `rst_i` asserted during the 2nd write → all outputs 0 asynchronously, and no further requests. A fresh start afterwards completes normally.
- **Error abort (`MAC_CTRL_ERR_EN`).** `mem_err_i` on the 4th read's `mem_rvalid_i` → no further requests, and `done_o` = `err_o` = 1 in the next cycle.
